// File: rtl/fir_feed_pkg.sv
// Shared constants and the delivery FSM state type for the FIR sample feeder.
package fir_feed_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } feed_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level/full/empty and a combinational head.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   push, wr_data    - write strobe and data (dropped when full unless popping)
//   pop              - remove head (ignored when empty)
//   rd_data_c        - current head entry, valid when empty=0
//   full, empty      - registered status
//   level            - registered occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok, pop_ok;

  // Pointer/level update; a push into a full FIFO succeeds only alongside a pop.
  always_comb begin
    pop_ok   = pop && !empty_q;
    push_ok  = push && (!full_q || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == (ADDR_W+1)'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;

endmodule

// File: rtl/fir_sample_feeder.sv
// Upstream sample feeder for the FIR engine: buffers processor pushes and hands
// one sample per read_req handshake until the programmed block budget runs out.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   wr_en, wr_data              - processor push
//   full, empty, level          - FIFO status
//   overflow, ovf_clr           - sticky dropped-push flag and its clear
//   cnt_load, cnt_value         - load sample budget
//   remaining                   - samples still to deliver
//   read_req                    - engine request (level)
//   read_ready, read_data       - one-cycle delivery pulse and registered sample
//   read_quit                   - budget exhausted
module fir_sample_feeder #(
  parameter int unsigned DATA_W = fir_feed_pkg::DATA_W,
  parameter int unsigned DEPTH  = fir_feed_pkg::DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [ADDR_W:0]               level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  input  logic                          cnt_load,
  input  logic [fir_feed_pkg::CNT_W-1:0] cnt_value,
  output logic [fir_feed_pkg::CNT_W-1:0] remaining,
  input  logic                          read_req,
  output logic                          read_ready,
  output logic [DATA_W-1:0]             read_data,
  output logic                          read_quit
);

  import fir_feed_pkg::*;

  feed_state_e       state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              read_quit_q, read_quit_d;
  logic              read_ready_q, read_ready_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W:0]   fifo_level;
  logic              pop_c, drop_c;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .wr_data   (wr_data),
    .pop       (pop_c),
    .rd_data_c (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Delivery FSM, budget counter and overflow flag.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    read_ready_d = 1'b0;
    read_data_d  = read_data_q;
    overflow_d   = overflow_q;
    pop_c        = 1'b0;
    drop_c       = 1'b0;
    read_quit_d  = (remaining_q == '0);

    unique case (state_q)
      IDLE: begin
        if (read_req && !fifo_empty && (remaining_q != '0)) begin
          pop_c        = 1'b1;
          read_ready_d = 1'b1;
          read_data_d  = fifo_head;
          state_d      = SERVE;
        end
      end
      // Dead cycle lets the engine drop read_req before another pop can occur.
      SERVE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cnt_load) begin
      remaining_d = cnt_value;
    end else if (pop_c) begin
      remaining_d = remaining_q - CNT_W'(1);
    end

    drop_c = wr_en && fifo_full && !pop_c;
    if (drop_c) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      read_quit_q  <= 1'b1;
      read_ready_q <= 1'b0;
      read_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      read_quit_q  <= read_quit_d;
      read_ready_q <= read_ready_d;
      read_data_q  <= read_data_d;
      overflow_q   <= overflow_d;
    end
  end

  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign level      = fifo_level;
  assign overflow   = overflow_q;
  assign remaining  = remaining_q;
  assign read_ready = read_ready_q;
  assign read_data  = read_data_q;
  assign read_quit  = read_quit_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: directed scenarios plus random traffic, all
// checked against a queue-based model of the feeder's behaviour.
module tb_fir_sample_feeder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full, empty, overflow;
  logic [4:0]  level;
  logic        ovf_clr = 1'b0;
  logic        cnt_load = 1'b0;
  logic [15:0] cnt_value = '0;
  logic [15:0] remaining;
  logic        read_req = 1'b0;
  logic        read_ready;
  logic [15:0] read_data;
  logic        read_quit;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [15:0] mq[$];
  logic [15:0] m_rem;
  logic        m_quit, m_ovf, m_ready;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  fir_sample_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .cnt_load   (cnt_load),
    .cnt_value  (cnt_value),
    .remaining  (remaining),
    .read_req   (read_req),
    .read_ready (read_ready),
    .read_data  (read_data),
    .read_quit  (read_quit)
  );

  // Advance the model over one edge using the current inputs, then clock the DUT.
  task automatic step();
    bit serve, drop;
    if (reset) begin
      mq.delete();
      m_rem = '0; m_quit = 1'b1; m_ovf = 1'b0; m_ready = 1'b0; m_data = '0;
    end else begin
      // A pulse last cycle means the feeder is in its dead cycle now.
      serve = !m_ready && read_req && (mq.size() != 0) && (m_rem != 0);
      drop  = wr_en && (mq.size() == DEPTH) && !serve;
      m_quit = (m_rem == 0);
      if (cnt_load) m_rem = cnt_value;
      else if (serve) m_rem = m_rem - 16'd1;
      m_ready = serve;
      if (serve) m_data = mq.pop_front();
      if (wr_en && !drop) mq.push_back(wr_data);
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; ovf_clr = 1'b0; cnt_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
    n_vec++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", read_ready); end
    n_vec++; if (read_data !== 16'h0) begin n_err++; $display("FAIL reset_data got %h exp 0000", read_data); end
    n_vec++; if (read_quit !== 1'b1) begin n_err++; $display("FAIL reset_quit got %b exp 1", read_quit); end
    n_vec++; if (remaining !== 16'd0) begin n_err++; $display("FAIL reset_remaining got %0d exp 0", remaining); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_basic_block();
    logic [15:0] vals [3];
    int pulses = 0;
    int pushed = 0;
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
    cnt_value = 16'd3; cnt_load = 1'b1; step();
    n_vec++; if (remaining !== 16'd3) begin n_err++; $display("FAIL basic_load got %0d exp 3", remaining); end
    n_vec++; if (read_quit !== 1'b1) begin n_err++; $display("FAIL basic_quit_lag got %b exp 1", read_quit); end
    read_req = 1'b1;
    for (int c = 0; c < 30 && pulses < 3; c++) begin
      if (pushed < 3) begin wr_en = 1'b1; wr_data = vals[pushed]; pushed++; end
      step();
      n_vec++; if (read_ready !== m_ready) begin n_err++; $display("FAIL basic_ready cyc %0d got %b exp %b", c, read_ready, m_ready); end
      if (read_ready) begin
        n_vec++;
        if (read_data !== vals[pulses]) begin n_err++; $display("FAIL basic_data pulse %0d got %h exp %h", pulses, read_data, vals[pulses]); end
        pulses++;
        read_req = 1'b0;
      end else begin
        read_req = (pulses < 3);
      end
    end
    read_req = 1'b0;
    n_vec++; if (pulses != 3) begin n_err++; $display("FAIL basic_pulse_count got %0d exp 3", pulses); end
    n_vec++; if (remaining !== 16'd0) begin n_err++; $display("FAIL basic_remaining got %0d exp 0", remaining); end
    n_vec++; if (read_quit !== 1'b0) begin n_err++; $display("FAIL basic_quit_early got %b exp 0", read_quit); end
    step();
    n_vec++; if (read_quit !== 1'b1) begin n_err++; $display("FAIL basic_quit got %b exp 1", read_quit); end
    n_vec++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL basic_no_extra got %b exp 0", read_ready); end
  endtask

  task automatic test_empty_wait();
    cnt_value = 16'd5; cnt_load = 1'b1; read_req = 1'b1; step();
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL wait_no_pulse cyc %0d got %b exp 0", c, read_ready); end
    end
    wr_en = 1'b1; wr_data = 16'h1234; step();
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL wait_empty got %b exp 0", empty); end
    n_vec++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL wait_early got %b exp 0", read_ready); end
    step();
    n_vec++; if (read_ready !== 1'b1) begin n_err++; $display("FAIL wait_pulse got %b exp 1", read_ready); end
    n_vec++; if (read_data !== 16'h1234) begin n_err++; $display("FAIL wait_data got %h exp 1234", read_data); end
    n_vec++; if (remaining !== 16'd4) begin n_err++; $display("FAIL wait_remaining got %0d exp 4", remaining); end
    read_req = 1'b0; step();
    n_vec++; if (read_data !== 16'h1234) begin n_err++; $display("FAIL wait_hold got %h exp 1234", read_data); end
  endtask

  task automatic test_overflow();
    read_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 16'($urandom); step();
    end
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b exp 1", full); end
    n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level got %0d exp 16", level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre got %b exp 0", overflow); end
    wr_en = 1'b1; wr_data = 16'hBEEF; step();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", overflow); end
    n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level_after got %0d exp 16", level); end
    wr_en = 1'b1; wr_data = 16'hBEEF; ovf_clr = 1'b1; step();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
    ovf_clr = 1'b1; step();
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b exp 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    int pulses = 0;
    logic [15:0] last = '0;
    cnt_value = 16'd20; cnt_load = 1'b1; step();
    read_req = 1'b1; wr_en = 1'b1; wr_data = 16'hCAFE; step();
    n_vec++; if (read_ready !== 1'b1) begin n_err++; $display("FAIL fpp_pulse got %b exp 1", read_ready); end
    n_vec++; if (read_data !== m_data) begin n_err++; $display("FAIL fpp_data got %h exp %h", read_data, m_data); end
    n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL fpp_level got %0d exp 16", level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow got %b exp 0", overflow); end
    for (int c = 0; c < 80 && pulses < DEPTH; c++) begin
      step();
      if (read_ready) begin
        n_vec++;
        if (read_data !== m_data) begin n_err++; $display("FAIL fpp_drain pulse %0d got %h exp %h", pulses, read_data, m_data); end
        last = read_data;
        pulses++;
      end
    end
    read_req = 1'b0;
    n_vec++; if (pulses != DEPTH) begin n_err++; $display("FAIL fpp_count got %0d exp %0d", pulses, DEPTH); end
    n_vec++; if (last !== 16'hCAFE) begin n_err++; $display("FAIL fpp_last got %h exp cafe", last); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fpp_empty got %b exp 1", empty); end
    n_vec++; if (remaining !== 16'd3) begin n_err++; $display("FAIL fpp_remaining got %0d exp 3", remaining); end
  endtask

  task automatic test_reset_mid();
    read_req = 1'b0;
    cnt_value = 16'd4; cnt_load = 1'b1; step();
    for (int i = 0; i < 6; i++) begin wr_en = 1'b1; wr_data = 16'(i + 16'h40); step(); end
    n_vec++; if (remaining !== 16'd4) begin n_err++; $display("FAIL mid_pre_rem got %0d exp 4", remaining); end
    n_vec++; if (level !== 5'd6) begin n_err++; $display("FAIL mid_pre_level got %0d exp 6", level); end
    reset = 1'b1; read_req = 1'b1; step(); reset = 1'b0;
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL mid_level got %0d exp 0", level); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b exp 1", empty); end
    n_vec++; if (remaining !== 16'd0) begin n_err++; $display("FAIL mid_remaining got %0d exp 0", remaining); end
    n_vec++; if (read_quit !== 1'b1) begin n_err++; $display("FAIL mid_quit got %b exp 1", read_quit); end
    n_vec++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready got %b exp 0", read_ready); end
    n_vec++; if (read_data !== 16'h0) begin n_err++; $display("FAIL mid_data got %h exp 0000", read_data); end
    wr_en = 1'b1; wr_data = 16'h5555; step();
    for (int c = 0; c < 5; c++) begin
      step();
      n_vec++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL mid_unserved cyc %0d got %b exp 0", c, read_ready); end
    end
    n_vec++; if (level !== 5'd1) begin n_err++; $display("FAIL mid_retained got %0d exp 1", level); end
    read_req = 1'b0;
  endtask

  task automatic test_random();
    reset = 1'b1; step(); reset = 1'b0;
    cnt_value = 16'($urandom_range(1, 40)); cnt_load = 1'b1; step();
    for (int c = 0; c < 600; c++) begin
      wr_en    = ($urandom_range(0, 99) < 55);
      wr_data  = 16'($urandom);
      read_req = ($urandom_range(0, 99) < 60);
      ovf_clr  = ($urandom_range(0, 99) < 5);
      cnt_load = ($urandom_range(0, 99) < 4);
      cnt_value = 16'($urandom_range(0, 30));
      reset    = ($urandom_range(0, 199) == 0);
      step();
      reset = 1'b0;
      n_vec++;
      if (read_ready !== m_ready || read_data !== m_data) begin
        n_err++; $display("FAIL rand_read cyc %0d got %b/%h exp %b/%h", c, read_ready, read_data, m_ready, m_data);
      end
      n_vec++;
      if (level !== 5'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
        n_err++; $display("FAIL rand_fifo cyc %0d got lvl %0d e%b f%b exp lvl %0d", c, level, empty, full, mq.size());
      end
      n_vec++;
      if (remaining !== m_rem || read_quit !== m_quit) begin
        n_err++; $display("FAIL rand_budget cyc %0d got %0d/%b exp %0d/%b", c, remaining, read_quit, m_rem, m_quit);
      end
      n_vec++;
      if (overflow !== m_ovf) begin
        n_err++; $display("FAIL rand_overflow cyc %0d got %b exp %b", c, overflow, m_ovf);
      end
    end
    read_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_empty_wait();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
